// File: rtl/i2s_tx_master.sv
// i2s_tx_master: single-clock Philips I2S master transmitter.
// Divides clk down to BCLK, frames stereo samples MSB first with the
// one-bit I2S delay, and decouples the producer through a one-entry
// holding buffer loaded over a valid/ready handshake.
// Optional build macro: I2S_TX_UNDERRUN_ZERO_EN (mute the frame on underrun
// instead of retransmitting the previous one).
module i2s_tx_master #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdout,
    output logic              frame_start,
    output logic              underrun
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);

    // Holding-buffer states
    localparam logic [0:0] BUF_EMPTY = 1'b0;
    localparam logic [0:0] BUF_FULL  = 1'b1;

    logic [DIV_W-1:0]    div_cnt_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic [0:0]          buf_state_r;
    logic [0:0]          buf_state_nxt_s;
    logic [2*DATA_W-1:0] buf_r;
    logic [2*DATA_W-1:0] frame_r;
    logic [2*DATA_W-1:0] frame_nxt_s;

    logic                tick_fall_s;
    logic                load_s;
    logic                accept_s;
    logic [BIT_W-1:0]    bit_nxt_s;
    logic                right_nxt_s;
    logic [BIT_W-1:0]    pos_nxt_s;
    logic [DATA_W-1:0]   slot_sample_s;
    logic                sdout_nxt_s;

    assign tick_fall_s = (div_cnt_r == DIV_LAST);
    assign load_s      = tick_fall_s && (bit_cnt_r == BIT_LAST);
    // The buffer is only offered while out of reset so nothing is captured during reset.
    assign s_ready     = rst_n && (buf_state_r == BUF_EMPTY);
    assign accept_s    = s_valid && (buf_state_r == BUF_EMPTY);

    // Slot position that becomes current at the next BCLK falling edge; the serial outputs are registered against it.
    always_comb begin
        bit_nxt_s     = bit_cnt_r;
        right_nxt_s   = 1'b0;
        pos_nxt_s     = bit_cnt_r;
        slot_sample_s = frame_r[2*DATA_W-1:DATA_W];
        sdout_nxt_s   = 1'b0;
        if (bit_cnt_r == BIT_LAST) begin
            bit_nxt_s = {BIT_W{1'b0}};
        end else begin
            bit_nxt_s = bit_cnt_r + BIT_W'(1);
        end
        right_nxt_s = (bit_nxt_s >= SLOT_LEN);
        if (right_nxt_s) begin
            pos_nxt_s     = bit_nxt_s - SLOT_LEN;
            slot_sample_s = frame_r[DATA_W-1:0];
        end else begin
            pos_nxt_s     = bit_nxt_s;
            slot_sample_s = frame_r[2*DATA_W-1:DATA_W];
        end
        // Position 0 is the I2S delay bit and positions past DATA_W pad with zero.
        for (int i = 0; i < DATA_W; i++) begin
            if (pos_nxt_s == BIT_W'(DATA_W - i)) begin
                sdout_nxt_s = slot_sample_s[i];
            end else begin
                sdout_nxt_s = sdout_nxt_s;
            end
        end
    end

    // Holding-buffer next state and frame-register load selection.
    always_comb begin
        buf_state_nxt_s = buf_state_r;
        frame_nxt_s     = frame_r;
        case (buf_state_r)
            BUF_EMPTY: begin
                // A pair accepted on the loading edge waits for the following frame.
                if (s_valid) begin
                    buf_state_nxt_s = BUF_FULL;
                end else begin
                    buf_state_nxt_s = BUF_EMPTY;
                end
                if (load_s) begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
                    frame_nxt_s = {(2*DATA_W){1'b0}};
`else
                    frame_nxt_s = frame_r;
`endif
                end else begin
                    frame_nxt_s = frame_r;
                end
            end
            BUF_FULL: begin
                if (load_s) begin
                    buf_state_nxt_s = BUF_EMPTY;
                    frame_nxt_s     = buf_r;
                end else begin
                    buf_state_nxt_s = BUF_FULL;
                    frame_nxt_s     = frame_r;
                end
            end
            default: begin
                buf_state_nxt_s = BUF_EMPTY;
                frame_nxt_s     = frame_r;
            end
        endcase
    end

    // BCLK divider: 50 % duty bit clock, falling edge marks tick_fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk      <= 1'b0;
        end else begin
            if (tick_fall_s) begin
                div_cnt_r <= {DIV_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            if (div_cnt_r == DIV_HALF) begin
                bclk <= 1'b1;
            end else if (tick_fall_s) begin
                bclk <= 1'b0;
            end else begin
                bclk <= bclk;
            end
        end
    end

    // Frame bit counter and serial outputs, all advanced on the BCLK falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            lrclk     <= 1'b0;
            sdout     <= 1'b0;
        end else if (tick_fall_s) begin
            bit_cnt_r <= bit_nxt_s;
            lrclk     <= right_nxt_s;
            sdout     <= sdout_nxt_s;
        end else begin
            bit_cnt_r <= bit_cnt_r;
            lrclk     <= lrclk;
            sdout     <= sdout;
        end
    end

    // Holding buffer capture and frame register update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_state_r <= BUF_EMPTY;
            buf_r       <= {(2*DATA_W){1'b0}};
            frame_r     <= {(2*DATA_W){1'b0}};
        end else begin
            buf_state_r <= buf_state_nxt_s;
            frame_r     <= frame_nxt_s;
            if (accept_s) begin
                buf_r <= {s_left, s_right};
            end else begin
                buf_r <= buf_r;
            end
        end
    end

    // Frame-load status pulses, one cycle after the loading tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load_s;
            underrun    <= load_s && (buf_state_r == BUF_EMPTY);
        end
    end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed, table-driven bench for i2s_tx_master (default parameters).
module tb_i2s_tx_master;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_left;
    logic [23:0] s_right;
    logic        bclk;
    logic        lrclk;
    logic        sdout;
    logic        frame_start;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0] cap_sd = 64'h0;
    logic [63:0] cap_lr = 64'h0;

    typedef struct {
        int          cyc;
        logic        rdy;
        logic        fs;
        logic        ur;
        logic        bc;
        logic        lr;
        logic        cf;
        logic [23:0] fl;
        logic [23:0] fr;
        logic        v;
        logic [23:0] l;
        logic [23:0] r;
    } vec_t;

    vec_t vecs[21];
    vec_t vecs2[4];

    i2s_tx_master dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdout       (sdout),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record serial data and word select at every BCLK rising edge.
    always @(posedge bclk) begin
        cap_sd <= {cap_sd[62:0], sdout};
        cap_lr <= {cap_lr[62:0], lrclk};
    end

    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at cyc %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, {63'h0, s_ready}, 64'h0);
        chk({tag, "_bclk"}, {63'h0, bclk}, 64'h0);
        chk({tag, "_lrclk"}, {63'h0, lrclk}, 64'h0);
        chk({tag, "_sdout"}, {63'h0, sdout}, 64'h0);
        chk({tag, "_frame_start"}, {63'h0, frame_start}, 64'h0);
        chk({tag, "_underrun"}, {63'h0, underrun}, 64'h0);
    endtask

    task automatic run_vec(input vec_t v);
        while (cyc < v.cyc) tick();
        chk("s_ready", {63'h0, s_ready}, {63'h0, v.rdy});
        chk("frame_start", {63'h0, frame_start}, {63'h0, v.fs});
        chk("underrun", {63'h0, underrun}, {63'h0, v.ur});
        chk("bclk", {63'h0, bclk}, {63'h0, v.bc});
        chk("lrclk", {63'h0, lrclk}, {63'h0, v.lr});
        if (v.cf) begin
            chk("frame_data", cap_sd, {1'b0, v.fl, 7'h00, 1'b0, v.fr, 7'h00});
            chk("frame_lrclk", cap_lr, {32'h0000_0000, 32'hFFFF_FFFF});
        end
        s_valid = v.v;
        s_left  = v.l;
        s_right = v.r;
    endtask

    function automatic vec_t mk(input int c, input logic rdy, input logic fs, input logic ur,
                                input logic bc, input logic lr, input logic cf,
                                input logic [23:0] fl, input logic [23:0] fr,
                                input logic v, input logic [23:0] l, input logic [23:0] r);
        vec_t t;
        t.cyc = c; t.rdy = rdy; t.fs = fs; t.ur = ur; t.bc = bc; t.lr = lr;
        t.cf = cf; t.fl = fl; t.fr = fr; t.v = v; t.l = l; t.r = r;
        return t;
    endfunction

    initial begin
        logic [23:0] p1l, p1r, p2l, p2r, p3l, p3r, p4l, p4r, p5l, p5r, ufl, ufr, z;
        p1l = 24'hA5A5A5; p1r = 24'h5A5A5A;
        p2l = 24'h123456; p2r = 24'hFEDCBA;
        p3l = 24'h800001; p3r = 24'h7FFFFE;
        p4l = 24'hABCDEF; p4r = 24'h000000;
        p5l = 24'h111111; p5r = 24'h222222;
        z   = 24'h000000;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        ufl = 24'h000000; ufr = 24'h000000;
`else
        ufl = p1l; ufr = p1r;
`endif
        //              cyc  rdy fs  ur  bclk lr  frm  exp_l exp_r  valid  L    R
        vecs[0]  = mk(   1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,   z,   1'b1, p1l, p1r);
        vecs[1]  = mk(   2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs[2]  = mk(   3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs[3]  = mk(   4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs[4]  = mk(   5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs[5]  = mk(   6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs[6]  = mk( 127, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs[7]  = mk( 128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, z,   z,   1'b0, z,   z);
        vecs[8]  = mk( 255, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, z,   z,   1'b0, z,   z);
        vecs[9]  = mk( 256, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, z,   z,   1'b0, z,   z);
        vecs[10] = mk( 257, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs[11] = mk( 511, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, z,   z,   1'b1, p2l, p2r);
        vecs[12] = mk( 512, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, p1l, p1r, 1'b1, p3l, p3r);
        vecs[13] = mk( 513, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,   z,   1'b1, p3l, p3r);
        vecs[14] = mk( 767, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, z,   z,   1'b1, p3l, p3r);
        vecs[15] = mk( 768, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ufl, ufr, 1'b1, p3l, p3r);
        vecs[16] = mk( 769, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs[17] = mk(1024, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, p2l, p2r, 1'b1, p4l, p4r);
        vecs[18] = mk(1025, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs[19] = mk(1280, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, p3l, p3r, 1'b1, p5l, p5r);
        vecs[20] = mk(1281, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        // After the mid-frame reset: buffered P5 is lost, frames stay silent and flagged.
        vecs2[0] = mk(   1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs2[1] = mk( 256, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, z,   z,   1'b0, z,   z);
        vecs2[2] = mk( 257, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,   z,   1'b0, z,   z);
        vecs2[3] = mk( 512, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, z,   z,   1'b0, z,   z);

        // Reset hold with a valid pair presented.
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_left  = p1l;
        s_right = p1r;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all_zero("reset_hold");
        end
        rst_n   = 1'b1;
        s_valid = 1'b0;
        cyc     = 0;

        for (int i = 0; i < 21; i++) run_vec(vecs[i]);

        // Reset at bit_cnt = 40 with P5 sitting in the buffer.
        while (cyc < 1441) tick();
        rst_n = 1'b0;
        tick();
        chk_all_zero("mid_reset");
        tick();
        tick();
        chk_all_zero("mid_reset_hold");
        rst_n = 1'b1;
        cyc   = 0;

        for (int i = 0; i < 4; i++) run_vec(vecs2[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
